// File: rtl/magma_valid_delay_line.sv
// Stallable WIDTH x DEPTH delay line with valid tags, flush and live occupancy.
// Define MAGMA_DELAY_ASSERT_EN to compile in the inline SVA checks.
module magma_valid_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH+1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    occ_d   = occ_q;
    if (FLUSH) begin
      valid_d = '0;
      occ_d   = '0;
    end else if (CE) begin
      data_d[0]  = I;
      valid_d[0] = I_valid;
      for (int k = 1; k < DEPTH; k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      // enter and exit in the same cycle cancel out
      occ_d = occ_q + OCC_W'(I_valid)
                    - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q  <= '{default: '0};
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign O         = data_q[DEPTH-1];
  assign O_valid   = valid_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef MAGMA_DELAY_ASSERT_EN
  logic chk_dis;
  logic chk_in;
  logic chk_occ_ok;
  assign chk_dis    = RESET || FLUSH;
  assign chk_in     = CE && I_valid;
  assign chk_occ_ok = (occupancy == OCC_W'($countones(valid_q)))
                   && (occupancy <= OCC_W'(DEPTH));

  for (genvar k = 1; k < DEPTH; k++) begin : g_chk
    logic chk_adv;
    assign chk_adv = CE && valid_q[k-1];
    a_adv: assert property (@(posedge CLK) disable iff (chk_dis)
      chk_adv |=> valid_q[k] && data_q[k] == $past(data_q[k-1]));
  end

  a_in: assert property (@(posedge CLK) disable iff (chk_dis)
    chk_in |=> valid_q[0] && data_q[0] == $past(I));

  a_stall: assert property (@(posedge CLK) disable iff (chk_dis)
    !CE |=> $stable(O) && $stable(O_valid) && $stable(occupancy));

  a_occ: assert property (@(posedge CLK) disable iff (chk_dis)
    chk_occ_ok);
`endif

endmodule

// File: tb/tb_magma_valid_delay_line.sv
// Bench for magma_valid_delay_line: vector table, corner sequences,
// and a random run against a time-indexed reference model.
module tb_magma_valid_delay_line;

  localparam int W = 8;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RESET, CE, FLUSH, I_valid;
  logic [W-1:0] I;
  logic [W-1:0] O;
  logic         O_valid;
  logic [2:0]   occupancy;

  logic r1, ce1, fl1, i1, iv1;
  logic o1, ov1;
  logic occ1;

  always #5 CLK = ~CLK;

  magma_valid_delay_line #(.WIDTH(W), .DEPTH(D)) u_dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .FLUSH(FLUSH),
    .I(I), .I_valid(I_valid),
    .O(O), .O_valid(O_valid), .occupancy(occupancy)
  );

  magma_valid_delay_line #(.WIDTH(1), .DEPTH(1)) u_dut1 (
    .CLK(CLK), .RESET(r1), .CE(ce1), .FLUSH(fl1),
    .I(i1), .I_valid(iv1),
    .O(o1), .O_valid(ov1), .occupancy(occ1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic r, c, f,
                       input logic [W-1:0] d, input logic v);
    RESET = r; CE = c; FLUSH = f; I = d; I_valid = v;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic         r, c, f;
    logic [W-1:0] d;
    logic         v;
    logic [W-1:0] eo;
    logic         ev;
    logic [2:0]   eocc;
  } vec_t;

  vec_t tv [16];

  typedef struct packed {
    logic [W-1:0] d;
    logic         v;
  } ent_t;

  ent_t hist [1024];
  int   cc;

  initial begin
    logic [W-1:0] got [$];
    int           peak;
    int           eocc;
    logic         rr, cr, fr, vr;
    logic [W-1:0] dr;

    drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
    r1 = 1'b1; ce1 = 1'b1; fl1 = 1'b0; i1 = 1'b1; iv1 = 1'b1;
    #1;

    // reset, single item, fill then flush
    tv[0]  = '{1,1,0,8'hFF,1, 8'h00,0,3'd0};
    tv[1]  = '{1,1,0,8'hFF,1, 8'h00,0,3'd0};
    tv[2]  = '{0,1,0,8'hA5,1, 8'h00,0,3'd1};
    tv[3]  = '{0,1,0,8'h00,0, 8'h00,0,3'd1};
    tv[4]  = '{0,1,0,8'h00,0, 8'h00,0,3'd1};
    tv[5]  = '{0,1,0,8'h00,0, 8'hA5,1,3'd1};
    tv[6]  = '{0,1,0,8'h00,0, 8'h00,0,3'd0};
    tv[7]  = '{0,1,0,8'h11,1, 8'h00,0,3'd1};
    tv[8]  = '{0,1,0,8'h22,1, 8'h00,0,3'd2};
    tv[9]  = '{0,1,0,8'h33,1, 8'h00,0,3'd3};
    tv[10] = '{0,1,0,8'h44,1, 8'h11,1,3'd4};
    tv[11] = '{0,1,1,8'h55,1, 8'h11,0,3'd0};
    tv[12] = '{0,1,0,8'h00,0, 8'h22,0,3'd0};
    tv[13] = '{0,1,0,8'h00,0, 8'h33,0,3'd0};
    tv[14] = '{0,1,0,8'h00,0, 8'h44,0,3'd0};
    tv[15] = '{0,1,0,8'h00,0, 8'h00,0,3'd0};

    for (int n = 0; n < 16; n++) begin
      drive(tv[n].r, tv[n].c, tv[n].f, tv[n].d, tv[n].v);
      step();
      chk($sformatf("vec%0d_O", n), 32'(O), 32'(tv[n].eo));
      chk($sformatf("vec%0d_Ov", n), 32'(O_valid), 32'(tv[n].ev));
      chk($sformatf("vec%0d_occ", n), 32'(occupancy), 32'(tv[n].eocc));
    end

    // stream 01..06 with a two-cycle stall after item 3
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    peak = 0;
    for (int n = 0; n < 16; n++) begin
      case (n)
        0, 1, 2:  drive(1'b0, 1'b1, 1'b0, W'(n + 1), 1'b1);
        3, 4:     drive(1'b0, 1'b0, 1'b0, 8'h04, 1'b1);
        5, 6, 7:  drive(1'b0, 1'b1, 1'b0, W'(n - 1), 1'b1);
        default:  drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      endcase
      step();
      if (CE && O_valid) got.push_back(O);
      if (int'(occupancy) > peak) peak = int'(occupancy);
    end
    chk("stall_count", 32'(got.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      if (k < got.size())
        chk($sformatf("stall_item%0d", k), 32'(got[k]), 32'(k + 1));
    chk("stall_peak", 32'(peak), 32'd4);

    // reset with three items in flight
    drive(1'b0, 1'b1, 1'b0, 8'hC1, 1'b1); step();
    drive(1'b0, 1'b1, 1'b0, 8'hC2, 1'b1); step();
    drive(1'b0, 1'b1, 1'b0, 8'hC3, 1'b1); step();
    chk("mid_occ", 32'(occupancy), 32'd3);
    drive(1'b1, 1'b1, 1'b0, 8'hC4, 1'b1); step();
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_Ov", 32'(O_valid), 32'd0);
    for (int n = 0; n < 6; n++) begin
      if (n == 0) drive(1'b0, 1'b1, 1'b0, 8'h77, 1'b1);
      else        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      step();
      chk($sformatf("post_rst_Ov%0d", n), 32'(O_valid),
          32'(n == 3));
      if (n == 3) chk("post_rst_O", 32'(O), 32'h77);
    end

    // DEPTH=1, WIDTH=1 instance
    step();
    r1 = 1'b0; i1 = 1'b1; iv1 = 1'b1; ce1 = 1'b1;
    step();
    chk("d1_O", 32'(o1), 32'd1);
    chk("d1_Ov", 32'(ov1), 32'd1);
    chk("d1_occ", 32'(occ1), 32'd1);
    i1 = 1'b0; iv1 = 1'b0;
    step();
    chk("d1_Ov_clr", 32'(ov1), 32'd0);
    chk("d1_occ_clr", 32'(occ1), 32'd0);

    // random run: hist[t] holds what entered on enabled edge t
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    for (int j = 0; j < D; j++) hist[j] = '0;
    cc = D;
    for (int n = 0; n < 600; n++) begin
      rr = ($urandom_range(99) < 3);
      fr = ($urandom_range(99) < 5);
      cr = ($urandom_range(99) < 75);
      vr = ($urandom_range(99) < 60);
      dr = W'($urandom);
      drive(rr, cr, fr, dr, vr);
      step();
      if (rr) begin
        for (int j = cc - D; j < cc; j++) hist[j] = '0;
      end else if (fr) begin
        for (int j = cc - D; j < cc; j++) hist[j].v = 1'b0;
      end else if (cr) begin
        hist[cc] = '{d: dr, v: vr};
        cc++;
      end
      eocc = 0;
      for (int j = cc - D; j < cc; j++) eocc += int'(hist[j].v);
      chk($sformatf("rnd%0d_O", n), 32'(O), 32'(hist[cc-D].d));
      chk($sformatf("rnd%0d_Ov", n), 32'(O_valid), 32'(hist[cc-D].v));
      chk($sformatf("rnd%0d_occ", n), 32'(occupancy), 32'(eocc));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
